// File: rtl/uart_core_p.sv
// uart_core_p: parametrised full-duplex UART (data width, stop bits, bit period).
// Define UART_PARITY_EN to insert/check a parity bit (PARITY_ODD selects odd).
module uart_core_p #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] DATA_END = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_END = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_tick;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick = (tx_cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (tx_state != S_IDLE)
        tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
      unique case (tx_state)
        S_IDLE: if (tx_start) begin
          tx_sh    <= tx_data;
`ifdef UART_PARITY_EN
          tx_par   <= (^tx_data) ^ PARITY_ODD[0];
`endif
          tx       <= 1'b0;
          tx_busy  <= 1'b1;
          tx_cnt   <= '0;
          tx_state <= S_START;
        end
        S_START: if (tx_tick) begin
          tx       <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_idx   <= '0;
          tx_state <= S_DATA;
        end
        S_DATA: if (tx_tick) begin
          if (tx_idx == DATA_END) begin
            tx_idx   <= '0;
`ifdef UART_PARITY_EN
            tx       <= tx_par;
            tx_state <= S_PAR;
`else
            tx       <= 1'b1;
            tx_state <= S_STOP;
`endif
          end else begin
            tx     <= tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: if (tx_tick) begin
          tx       <= 1'b1;
          tx_state <= S_STOP;
        end
`endif
        S_STOP: if (tx_tick) begin
          if (tx_idx == STOP_END) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            tx_state <= S_IDLE;
          end else begin
            tx_idx <= tx_idx + 4'd1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic                 rx_s1, rx_s2;
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_fe;
  logic                 rx_armed;
  logic                 rx_tick;
  logic                 stop_bad;
`ifdef UART_PARITY_EN
  logic                 rx_pe;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // start bit is checked at its midpoint, every later bit one period on
  assign rx_tick  = (rx_state == S_START) ? (rx_cnt == HALF_END)
                                          : (rx_cnt == BIT_END);
  assign stop_bad = rx_fe | ~rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_sh        <= '0;
      rx_fe        <= 1'b0;
      rx_armed     <= 1'b1;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pe         <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      if (rx_state != S_IDLE)
        rx_cnt <= rx_tick ? '0 : rx_cnt + CW'(1);
      unique case (rx_state)
        S_IDLE: begin
          rx_armed <= rx_armed | rx_s2;
          if (rx_armed && !rx_s2) begin
            rx_cnt   <= '0;
            rx_fe    <= 1'b0;
            rx_state <= S_START;
          end
        end
        S_START: if (rx_tick) begin
          rx_idx   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_tick) begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == DATA_END) begin
            rx_idx   <= '0;
`ifdef UART_PARITY_EN
            rx_state <= S_PAR;
`else
            rx_state <= S_STOP;
`endif
          end else begin
            rx_idx <= rx_idx + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: if (rx_tick) begin
          rx_pe    <= (^rx_sh) ^ rx_s2 ^ PARITY_ODD[0];
          rx_state <= S_STOP;
        end
`endif
        S_STOP: if (rx_tick) begin
          if (rx_idx == STOP_END) begin
            rx_data      <= rx_sh;
            rx_frame_err <= stop_bad;
`ifdef UART_PARITY_EN
            rx_parity_err <= rx_pe;
`endif
            rx_done      <= 1'b1;
            // a low stop bit must see the line high again before rearming
            rx_armed     <= ~stop_bad;
            rx_state     <= S_IDLE;
          end else begin
            rx_fe  <= stop_bad;
            rx_idx <= rx_idx + 4'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0 & PARITY_ODD[0];
`endif

endmodule
